// File: rtl/rs_pkg.sv
// Opcode map and tag helpers shared by the age-ordered reservation station.
package rs_pkg;

    typedef logic [6:0] opcode_t;

    localparam opcode_t OP_JALR  = 7'd4;
    localparam opcode_t OP_BEQ   = 7'd5;
    localparam opcode_t OP_BNE   = 7'd6;
    localparam opcode_t OP_BLT   = 7'd7;
    localparam opcode_t OP_BGE   = 7'd8;
    localparam opcode_t OP_BLTU  = 7'd9;
    localparam opcode_t OP_BGEU  = 7'd10;
    localparam opcode_t OP_ADDI  = 7'd19;
    localparam opcode_t OP_SLTI  = 7'd20;
    localparam opcode_t OP_SLTIU = 7'd21;
    localparam opcode_t OP_XORI  = 7'd22;
    localparam opcode_t OP_ORI   = 7'd23;
    localparam opcode_t OP_ANDI  = 7'd24;
    localparam opcode_t OP_SLLI  = 7'd25;
    localparam opcode_t OP_SRLI  = 7'd26;
    localparam opcode_t OP_SRAI  = 7'd27;
    localparam opcode_t OP_ADD   = 7'd28;
    localparam opcode_t OP_SUB   = 7'd29;
    localparam opcode_t OP_SLL   = 7'd30;
    localparam opcode_t OP_SLT   = 7'd31;
    localparam opcode_t OP_SLTU  = 7'd32;
    localparam opcode_t OP_XOR   = 7'd33;
    localparam opcode_t OP_SRL   = 7'd34;
    localparam opcode_t OP_SRA   = 7'd35;
    localparam opcode_t OP_OR    = 7'd36;
    localparam opcode_t OP_AND   = 7'd37;

    // Tag value meaning "operand already available".
    function automatic logic [31:0] non_dep(input int rob_w);
        return 32'd1 << rob_w;
    endfunction

endpackage

// File: rtl/rs_age_issue_if.sv
// Dispatch, CDB and result handshake bundle of the reservation station.
interface rs_age_issue_if
    import rs_pkg::*;
#(
    parameter int RoB_WIDTH = 4,
    parameter int NUM_CDB   = 2,
    parameter int XLEN      = 32
);
    logic                          new_entry_en;
    logic [RoB_WIDTH-1:0]          new_entry_robEntry;
    opcode_t                       new_entry_opcode;
    logic [XLEN-1:0]               new_entry_Vj;
    logic [XLEN-1:0]               new_entry_Vk;
    logic [RoB_WIDTH:0]            new_entry_Qj;
    logic [RoB_WIDTH:0]            new_entry_Qk;
    logic [XLEN-1:0]               new_entry_imm;
    logic [NUM_CDB-1:0]            cdb_valid;
    logic [NUM_CDB*RoB_WIDTH-1:0]  cdb_index;
    logic [NUM_CDB*XLEN-1:0]       cdb_data;
    logic                          out_valid;
    logic                          out_ready;
    logic [RoB_WIDTH-1:0]          out_rob_index;
    logic [XLEN-1:0]               out_data;

    modport master (
        output new_entry_en, new_entry_robEntry, new_entry_opcode,
        output new_entry_Vj, new_entry_Vk, new_entry_Qj, new_entry_Qk,
        output new_entry_imm, cdb_valid, cdb_index, cdb_data, out_ready,
        input  out_valid, out_rob_index, out_data
    );

    modport slave (
        input  new_entry_en, new_entry_robEntry, new_entry_opcode,
        input  new_entry_Vj, new_entry_Vk, new_entry_Qj, new_entry_Qk,
        input  new_entry_imm, cdb_valid, cdb_index, cdb_data, out_ready,
        output out_valid, out_rob_index, out_data
    );
endinterface

// File: rtl/rs_age_matrix.sv
// Older-than matrix: older[i][j] set means slot i was dispatched before slot j.
module rs_age_matrix #(
    parameter int N = 8
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         rdy_in,
    input  logic         flush,
    input  logic [N-1:0] busy,
    input  logic [N-1:0] alloc,
    input  logic [N-1:0] free,
    input  logic [N-1:0] ready,
    output logic [N-1:0] grant
);
    logic [N-1:0] older [N];
    logic [N-1:0] blocked;

    always_ff @(posedge clk_in) begin
        if (rst_in || (rdy_in && flush)) begin
            for (int i = 0; i < N; i++) older[i] <= '0;
        end else if (rdy_in) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    if (free[i] || free[j])
                        older[i][j] <= 1'b0;
                    else if (alloc[j])
                        older[i][j] <= busy[i];
                    else if (alloc[i])
                        older[i][j] <= 1'b0;
                end
            end
        end
    end

    // A ready slot is blocked when any other ready slot is older.
    always_comb begin
        blocked = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (ready[j] && older[j][i]) blocked[i] = 1'b1;
            end
        end
        grant = ready & ~blocked;
    end
endmodule

// File: rtl/rs_age_issue.sv
// Integer reservation station with CDB wakeup and oldest-first issue.
module rs_age_issue
    import rs_pkg::*;
#(
    parameter int RS_WIDTH  = 3,
    parameter int RoB_WIDTH = 4,
    parameter int NUM_CDB   = 2,
    parameter int XLEN      = 32
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              flush_signal,
    rs_age_issue_if.slave     bus,
    output logic [RS_WIDTH:0] free_count,
    output logic              isFull,
    output logic              isEmpty
);
    localparam int RS_SIZE = 1 << RS_WIDTH;
    localparam int QW = RoB_WIDTH + 1;
    localparam int FW = RS_WIDTH + 1;
    localparam logic [QW-1:0] NDEP = QW'(non_dep(RoB_WIDTH));

    logic [RS_SIZE-1:0]   busy;
    logic [RoB_WIDTH-1:0] rob [RS_SIZE];
    opcode_t              op  [RS_SIZE];
    logic [XLEN-1:0]      vj  [RS_SIZE];
    logic [XLEN-1:0]      vk  [RS_SIZE];
    logic [XLEN-1:0]      imm [RS_SIZE];
    logic [QW-1:0]        qj  [RS_SIZE];
    logic [QW-1:0]        qk  [RS_SIZE];

    logic [XLEN-1:0]      wvj [RS_SIZE];
    logic [XLEN-1:0]      wvk [RS_SIZE];
    logic [QW-1:0]        wqj [RS_SIZE];
    logic [QW-1:0]        wqk [RS_SIZE];
    logic [XLEN-1:0]      nvj, nvk;
    logic [QW-1:0]        nqj, nqk;

    logic [QW-1:0]        ctag [NUM_CDB];
    logic [XLEN-1:0]      cval [NUM_CDB];

    logic [RS_SIZE-1:0]   ready, grant, alloc, free_v;
    logic [RS_WIDTH-1:0]  slot, sel;
    logic                 accept, issue;
    logic [XLEN-1:0]      result;

    logic                 out_valid_q;
    logic [RoB_WIDTH-1:0] out_rob_q;
    logic [XLEN-1:0]      out_data_q;

    function automatic logic [XLEN-1:0] alu(
        input opcode_t o,
        input logic [XLEN-1:0] a, b, im
    );
        logic [XLEN-1:0] r;
        r = '0;
        case (o)
            OP_JALR:  r = (a + im) & ~XLEN'(1);
            OP_BEQ:   r = XLEN'(a == b);
            OP_BNE:   r = XLEN'(a != b);
            OP_BLT:   r = XLEN'($signed(a) < $signed(b));
            OP_BGE:   r = XLEN'($signed(a) >= $signed(b));
            OP_BLTU:  r = XLEN'(a < b);
            OP_BGEU:  r = XLEN'(a >= b);
            OP_ADDI:  r = a + im;
            OP_SLTI:  r = XLEN'($signed(a) < $signed(im));
            OP_SLTIU: r = XLEN'(a < im);
            OP_XORI:  r = a ^ im;
            OP_ORI:   r = a | im;
            OP_ANDI:  r = a & im;
            OP_SLLI:  r = a << im[4:0];
            OP_SRLI:  r = a >> im[4:0];
            OP_SRAI:  r = $signed(a) >>> im[4:0];
            OP_ADD:   r = a + b;
            OP_SUB:   r = a - b;
            OP_SLL:   r = a << b[4:0];
            OP_SLT:   r = XLEN'($signed(a) < $signed(b));
            OP_SLTU:  r = XLEN'(a < b);
            OP_XOR:   r = a ^ b;
            OP_SRL:   r = a >> b[4:0];
            OP_SRA:   r = $signed(a) >>> b[4:0];
            OP_OR:    r = a | b;
            OP_AND:   r = a & b;
            default:  r = '0;
        endcase
        return r;
    endfunction

    for (genvar k = 0; k < NUM_CDB; k++) begin : g_cdb
        assign ctag[k] = {1'b0, bus.cdb_index[k*RoB_WIDTH +: RoB_WIDTH]};
        assign cval[k] = bus.cdb_data[k*XLEN +: XLEN];
    end

    // Descending scan so the lowest matching port is the last writer.
    always_comb begin
        nqj = bus.new_entry_Qj;
        nvj = bus.new_entry_Vj;
        nqk = bus.new_entry_Qk;
        nvk = bus.new_entry_Vk;
        for (int i = 0; i < RS_SIZE; i++) begin
            wqj[i] = qj[i];
            wvj[i] = vj[i];
            wqk[i] = qk[i];
            wvk[i] = vk[i];
        end
        for (int k = NUM_CDB - 1; k >= 0; k--) begin
            if (bus.cdb_valid[k]) begin
                if (bus.new_entry_Qj == ctag[k]) begin
                    nqj = NDEP;
                    nvj = cval[k];
                end
                if (bus.new_entry_Qk == ctag[k]) begin
                    nqk = NDEP;
                    nvk = cval[k];
                end
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (qj[i] == ctag[k]) begin
                        wqj[i] = NDEP;
                        wvj[i] = cval[k];
                    end
                    if (qk[i] == ctag[k]) begin
                        wqk[i] = NDEP;
                        wvk[i] = cval[k];
                    end
                end
            end
        end
    end

    always_comb begin
        slot = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!busy[i]) slot = RS_WIDTH'(i);
        end
        accept = bus.new_entry_en && (free_count != '0);
        alloc = '0;
        if (accept) alloc[slot] = 1'b1;
    end

    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            ready[i] = busy[i] && (qj[i] == NDEP) && (qk[i] == NDEP);
        end
    end

    rs_age_matrix #(.N(RS_SIZE)) u_age (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rdy_in (rdy_in),
        .flush  (flush_signal),
        .busy   (busy),
        .alloc  (alloc),
        .free   (free_v),
        .ready  (ready),
        .grant  (grant)
    );

    always_comb begin
        sel = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (grant[i]) sel = RS_WIDTH'(i);
        end
        issue  = (!out_valid_q || bus.out_ready) && (|ready);
        free_v = issue ? grant : '0;
    end

    assign result = alu(op[sel], vj[sel], vk[sel], imm[sel]);

    always_ff @(posedge clk_in) begin
        if (rst_in || (rdy_in && flush_signal)) begin
            busy        <= '0;
            free_count  <= FW'(RS_SIZE);
            out_valid_q <= 1'b0;
            out_rob_q   <= '0;
            out_data_q  <= '0;
            for (int i = 0; i < RS_SIZE; i++) begin
                qj[i] <= NDEP;
                qk[i] <= NDEP;
            end
        end else if (rdy_in) begin
            busy <= (busy & ~free_v) | alloc;
            for (int i = 0; i < RS_SIZE; i++) begin
                if (alloc[i]) begin
                    rob[i] <= bus.new_entry_robEntry;
                    op[i]  <= bus.new_entry_opcode;
                    imm[i] <= bus.new_entry_imm;
                    vj[i]  <= nvj;
                    vk[i]  <= nvk;
                    qj[i]  <= nqj;
                    qk[i]  <= nqk;
                end else begin
                    vj[i] <= wvj[i];
                    vk[i] <= wvk[i];
                    qj[i] <= wqj[i];
                    qk[i] <= wqk[i];
                end
            end
            if (issue) begin
                out_valid_q <= 1'b1;
                out_rob_q   <= rob[sel];
                out_data_q  <= result;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
            free_count <= free_count + FW'(issue) - FW'(accept);
        end
    end

    assign bus.out_valid     = out_valid_q;
    assign bus.out_rob_index = out_rob_q;
    assign bus.out_data      = out_data_q;
    assign isFull  = (free_count == '0);
    assign isEmpty = (free_count == FW'(RS_SIZE));
endmodule
